// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared defaults and per-channel context type for the shared pattern detector.
package seq_det_pkg;
    localparam int NCH_DEF = 4;
    localparam int PAT_W_DEF = 4;
    localparam int CNT_W_DEF = 8;
    localparam logic [PAT_W_DEF-1:0] PATTERN_DEF = 4'b1010;
    localparam int CH_W = $clog2(NCH_DEF);
    typedef struct packed {
        logic [PAT_W_DEF-2:0] hist;
        logic [$clog2(PAT_W_DEF)-1:0] fill;
    } ctx_t;
endpackage

// File: rtl/seq_det_scheduler_rr_arbiter.sv
// rr_arbiter: round-robin grant of one requester per cycle, pointer advances past the winner.
module rr_arbiter #(
    parameter int NCH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NCH-1:0]         req,
    output logic [NCH-1:0]         gnt,
    output logic [$clog2(NCH)-1:0] gnt_idx,
    output logic                   gnt_vld
);
    localparam int IW = $clog2(NCH);
    logic [IW-1:0] ptr_q, ptr_d;
    int idx;
    // Scan from farthest to nearest so the last hit is the first requester at or after ptr.
    always_comb begin
        gnt_idx = '0;
        idx = 0;
        for (int i = NCH - 1; i >= 0; i--) begin
            idx = (int'(ptr_q) + i) % NCH;
            if (req[idx]) gnt_idx = IW'(idx);
        end
        gnt_vld = |req;
        gnt = gnt_vld ? NCH'(1) << gnt_idx : '0;
        ptr_d = !gnt_vld ? ptr_q : (int'(gnt_idx) == NCH - 1) ? '0 : gnt_idx + IW'(1);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr_q <= '0;
        else ptr_q <= ptr_d;
    end
endmodule

// File: rtl/seq_det_scheduler.sv
// seq_det_scheduler: overlapping PATTERN detector time-shared across NCH serial channels,
// with per-channel history context and saturating match counters.
module seq_det_scheduler
    import seq_det_pkg::*;
#(
    parameter int NCH = NCH_DEF,
    parameter int PAT_W = PAT_W_DEF,
    parameter logic [PAT_W-1:0] PATTERN = PATTERN_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NCH-1:0]         req,
    input  logic [NCH-1:0]         data_in,
    output logic [NCH-1:0]         gnt,
    input  logic                   clr_cnt,
    output logic                   y,
    output logic [$clog2(NCH)-1:0] y_ch,
    output logic [NCH*CNT_W-1:0]   match_cnt
);
    localparam int IW = $clog2(NCH);
    localparam int FW = $clog2(PAT_W);
    localparam logic [FW-1:0] FILL_MAX = FW'(PAT_W - 1);
    typedef struct packed {
        logic [PAT_W-2:0] hist;
        logic [FW-1:0] fill;
    } ch_ctx_t;
    logic [IW-1:0] gnt_idx;
    logic gnt_vld, bit_in, match;
    ch_ctx_t cur;
    ch_ctx_t ctx_q [NCH];
    ch_ctx_t ctx_d [NCH];
    logic [CNT_W-1:0] cnt_q [NCH];
    logic [CNT_W-1:0] cnt_d [NCH];
    logic y_q, y_d;
    logic [IW-1:0] y_ch_q, y_ch_d;
    rr_arbiter #(.NCH(NCH)) u_arb (
        .clk(clk),
        .rst(rst),
        .req(req),
        .gnt(gnt),
        .gnt_idx(gnt_idx),
        .gnt_vld(gnt_vld)
    );
    assign cur = ctx_q[gnt_idx];
    assign bit_in = data_in[gnt_idx];
    assign match = gnt_vld && (cur.fill == FILL_MAX) && ({cur.hist, bit_in} == PATTERN);
    always_comb begin
        ctx_d = ctx_q;
        if (gnt_vld) begin
            ctx_d[gnt_idx].hist = (PAT_W-1)'({cur.hist, bit_in});
            ctx_d[gnt_idx].fill = (cur.fill == FILL_MAX) ? cur.fill : cur.fill + FW'(1);
        end
        // Clear takes priority over a coincident match.
        for (int c = 0; c < NCH; c++) begin
            cnt_d[c] = clr_cnt ? '0 :
                       (match && gnt_idx == IW'(c) && cnt_q[c] != '1) ? cnt_q[c] + CNT_W'(1) : cnt_q[c];
            match_cnt[c*CNT_W +: CNT_W] = cnt_q[c];
        end
        y_d = match;
        y_ch_d = gnt_vld ? gnt_idx : y_ch_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < NCH; c++) begin
                ctx_q[c] <= '0;
                cnt_q[c] <= '0;
            end
            y_q <= 1'b0;
            y_ch_q <= '0;
        end else begin
            ctx_q <= ctx_d;
            cnt_q <= cnt_d;
            y_q <= y_d;
            y_ch_q <= y_ch_d;
        end
    end
    assign y = y_q;
    assign y_ch = y_ch_q;
endmodule

// File: tb/tb_seq_det_scheduler.sv
// tb_seq_det_scheduler: directed checks of arbitration, overlapping detection, counters and reset.
module tb_seq_det_scheduler;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [3:0] req = '0;
    logic [3:0] data_in = '0;
    logic [3:0] gnt;
    logic clr_cnt = 1'b0;
    logic y;
    logic [1:0] y_ch;
    logic [7:0] match_cnt;
    int errors = 0;
    int checks = 0;

    seq_det_scheduler #(.NCH(4), .PAT_W(4), .PATTERN(4'b1010), .CNT_W(2)) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .data_in(data_in),
        .gnt(gnt),
        .clr_cnt(clr_cnt),
        .y(y),
        .y_ch(y_ch),
        .match_cnt(match_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req = '0;
        data_in = '0;
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    task automatic send(input int ch, input logic b, input logic exp_y, input string tag);
        req = '0;
        data_in = '0;
        req[ch] = 1'b1;
        data_in[ch] = b;
        step();
        req = '0;
        chk(tag, 32'(y), 32'(exp_y));
    endtask

    function automatic logic [1:0] cnt_of(input int c);
        return match_cnt[c*2 +: 2];
    endfunction

    initial begin
        logic [3:0] p0;
        logic [3:0] exp_g;
        #12;
        rst = 1'b0;
        chk("rst_y", 32'(y), 0);
        chk("rst_ych", 32'(y_ch), 0);
        chk("rst_cnt", 32'(match_cnt), 0);
        req = 4'b1111;
        #1;
        chk("rst_gnt", 32'(gnt), 32'h1);
        req = '0;
        #1;
        chk("idle_gnt", 32'(gnt), 0);

        // single channel overlapping detection
        send(0, 1'b1, 1'b0, "t1_b1");
        send(0, 1'b0, 1'b0, "t1_b2");
        send(0, 1'b1, 1'b0, "t1_b3");
        send(0, 1'b0, 1'b1, "t1_b4");
        chk("t1_ych", 32'(y_ch), 0);
        send(0, 1'b1, 1'b0, "t1_b5");
        send(0, 1'b0, 1'b1, "t1_b6");
        chk("t1_cnt0", 32'(cnt_of(0)), 2);
        step();
        chk("t1_idle_y", 32'(y), 0);

        // round-robin fairness
        do_reset();
        req = 4'b1111;
        exp_g = 4'b0001;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk($sformatf("t2_gnt%0d", i), 32'(gnt), 32'(exp_g));
            step();
            exp_g = {exp_g[2:0], exp_g[3]};
        end
        req = '0;

        // context isolation
        do_reset();
        p0 = 4'b1010;
        req = 4'b0011;
        for (int i = 0; i < 8; i++) begin
            data_in = {2'b00, 1'b1, p0[3 - i/2]};
            #1;
            chk($sformatf("t3_gnt%0d", i), 32'(gnt), (i % 2 == 0) ? 32'h1 : 32'h2);
            step();
            chk($sformatf("t3_y%0d", i), 32'(y), (i == 6) ? 1 : 0);
            if (i == 6) chk("t3_ych", 32'(y_ch), 0);
        end
        req = '0;
        chk("t3_cnt1", 32'(cnt_of(1)), 0);
        chk("t3_cnt0", 32'(cnt_of(0)), 1);

        // saturation and clear priority
        do_reset();
        send(2, 1'b1, 1'b0, "t4_a");
        send(2, 1'b0, 1'b0, "t4_b");
        send(2, 1'b1, 1'b0, "t4_c");
        for (int m = 1; m <= 5; m++) begin
            send(2, 1'b0, 1'b1, $sformatf("t4_m%0d", m));
            chk($sformatf("t4_cnt%0d", m), 32'(cnt_of(2)), (m > 3) ? 3 : m);
            chk($sformatf("t4_ych%0d", m), 32'(y_ch), 2);
            send(2, 1'b1, 1'b0, $sformatf("t4_n%0d", m));
        end
        clr_cnt = 1'b1;
        send(2, 1'b0, 1'b1, "t4_clr_y");
        clr_cnt = 1'b0;
        chk("t4_clr_cnt", 32'(cnt_of(2)), 0);

        // asynchronous reset mid-stream
        do_reset();
        send(0, 1'b1, 1'b0, "t5_a");
        send(0, 1'b0, 1'b0, "t5_b");
        send(0, 1'b1, 1'b0, "t5_c");
        send(1, 1'b1, 1'b0, "t5_d");
        send(1, 1'b0, 1'b0, "t5_e");
        send(1, 1'b1, 1'b0, "t5_f");
        send(1, 1'b0, 1'b1, "t5_g");
        chk("t5_cnt1_pre", 32'(cnt_of(1)), 1);
        #3;
        rst = 1'b1;
        #1;
        chk("t5_rst_y", 32'(y), 0);
        chk("t5_rst_cnt", 32'(match_cnt), 0);
        req = 4'b1111;
        #1;
        chk("t5_rst_gnt", 32'(gnt), 32'h1);
        req = '0;
        rst = 1'b0;
        send(0, 1'b0, 1'b0, "t5_0");
        send(0, 1'b1, 1'b0, "t5_r1");
        send(0, 1'b0, 1'b0, "t5_r2");
        send(0, 1'b1, 1'b0, "t5_r3");
        send(0, 1'b0, 1'b1, "t5_r4");
        chk("t5_cnt0", 32'(cnt_of(0)), 1);

        // history persists over idle cycles
        send(3, 1'b1, 1'b0, "t6_a");
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("t6_idle%0d", i), 32'(y), 0);
        end
        send(3, 1'b0, 1'b0, "t6_b");
        send(3, 1'b1, 1'b0, "t6_c");
        send(3, 1'b0, 1'b1, "t6_d");
        chk("t6_ych", 32'(y_ch), 3);
        chk("t6_cnt3", 32'(cnt_of(3)), 1);
        step();
        chk("t6_pulse_end", 32'(y), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
